// File: rtl/imem_loader_if.sv
// ============================================================================
// imem_loader_if : byte-stream input and instruction-memory write bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output im_we,
    output im_addr,
    output im_wdata,
    output cpu_reset,
    output done,
    output err
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata,
    input  cpu_reset,
    input  done,
    input  err
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : parses a length-prefixed byte stream into instruction words
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W       = 10,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  wire logic     clk,
  input  wire logic     reset,
  imem_loader_if.master bus
);

  // The length header is 16 bits, so ADDR_W is expected to be at most 16.
  localparam int              IDLE_W     = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [16:0]     MAX_N      = 17'(64'd1 << ADDR_W);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [16:0]       k_q, k_d;
  logic [1:0]        b_q, b_d;
  logic [23:0]       asm_q, asm_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              ready;
  logic              accept;
  logic [15:0]       n_full;

  assign ready  = !reset && ((state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA));
  assign accept = ready && bus.in_valid;
  assign n_full = {n_q[15:8], bus.in_data};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    b_d     = b_q;
    asm_d   = asm_q;
    idle_d  = idle_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      LEN_HI: begin
        idle_d = '0;
        if (accept) begin
          n_d     = {bus.in_data, n_q[7:0]};
          state_d = LEN_LO;
        end
      end

      LEN_LO: begin
        if (idle_q == IDLE_LIMIT) begin
          state_d = ERROR;
        end else if (accept) begin
          n_d    = n_full;
          idle_d = '0;
          k_d    = '0;
          b_d    = '0;
          if (n_full == 16'd0) begin
            state_d = DONE;
          end else if ({1'b0, n_full} > MAX_N) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      DATA: begin
        // k reaches N on the edge that launches the final write, so this
        // fires in the im_we cycle and done rises right after the pulse.
        if (k_q == {1'b0, n_q}) begin
          state_d = DONE;
        end else if (idle_q == IDLE_LIMIT) begin
          state_d = ERROR;
        end else if (accept) begin
          idle_d = '0;
          asm_d  = {asm_q[15:0], bus.in_data};
          b_d    = b_q + 2'd1;
          if (b_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = k_q[ADDR_W-1:0];
            wdata_d = {asm_q, bus.in_data};
            k_d     = k_q + 17'd1;
          end
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      DONE, ERROR: begin
        idle_d = '0;
      end

      default: begin
        state_d = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LEN_HI;
      n_q     <= '0;
      k_q     <= '0;
      b_q     <= '0;
      asm_q   <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      b_q     <= b_d;
      asm_q   <= asm_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.im_we     = we_q;
  assign bus.im_addr   = addr_q;
  assign bus.im_wdata  = wdata_q;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == ERROR);
  assign bus.cpu_reset = (state_q != DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed vector bench for imem_loader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(
    .ADDR_W       (ADDR_W),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                we_runs    = 0;
  int                both_flags = 0;
  logic              prev_we    = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.im_we) begin
        wq_addr.push_back(bus.im_addr);
        wq_data.push_back(bus.im_wdata);
        if (prev_we) we_runs <= we_runs + 1;
      end
      if (bus.done && bus.err) both_flags <= both_flags + 1;
      prev_we <= bus.im_we;
    end else begin
      prev_we <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, {59'd0, bus.in_ready, bus.cpu_reset, bus.done, bus.err, bus.im_we}, 64'b01000);
    chk({tag, "_addr"},  64'(bus.im_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(bus.im_wdata), 64'd0);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    if (check) check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Holds in_valid low for gap cycles, then offers d; gives up only when the
  // loader has already reached a terminal state.
  task automatic send_byte(input logic [7:0] d, input int gap, output bit ok);
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    ok = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, inout bit ok);
    logic [31:0] t;
    for (int j = 3; j >= 0; j--) begin
      t = w >> (8 * j);
      if (ok) send_byte(t[7:0], gap, ok);
    end
  endtask

  typedef struct {
    int              pre;
    logic [15:0]     n;
    int              nsend;
    logic [3:0][31:0] w;
    int              gap;
    logic            exp_done;
    logic            exp_err;
    int              exp_wr;
  } vec_t;

  localparam int NV = 8;
  vec_t vt[NV];

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, TMO - 1)) : g;
  endfunction

  initial begin
    bit   ok;
    int   base;
    int   first;
    int   bad;
    logic [31:0] wd;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vt[0] = '{0, 16'd2,    2, {32'h0, 32'h0, 32'h8C090000, 32'h20080005},        0, 1'b1, 1'b0, 2};
    vt[1] = '{0, 16'd0,    0, {32'h0, 32'h0, 32'h0, 32'h0},                       0, 1'b1, 1'b0, 0};
    vt[2] = '{0, 16'd1025, 0, {32'h0, 32'h0, 32'h0, 32'h0},                       0, 1'b0, 1'b1, 0};
    vt[3] = '{0, 16'd3,    3, {32'h0, 32'hA5A55A5A, 32'h01234567, 32'hDEADBEEF}, -1, 1'b1, 1'b0, 3};
    vt[4] = '{0, 16'd1,    1, {32'h0, 32'h0, 32'h0, 32'hCAFEF00D},               15, 1'b1, 1'b0, 1};
    vt[5] = '{0, 16'd1,    1, {32'h0, 32'h0, 32'h0, 32'h12345678},               16, 1'b0, 1'b1, 0};
    vt[6] = '{40, 16'd1,   1, {32'h0, 32'h0, 32'h0, 32'h0BADC0DE},                0, 1'b1, 1'b0, 1};
    vt[7] = '{0, 16'd2,    1, {32'h0, 32'h0, 32'h0, 32'h55AA33CC},                0, 1'b0, 1'b1, 1};

    do_reset(1'b1);

    for (int v = 0; v < NV; v++) begin
      do_reset(1'b0);
      base = wq_addr.size();
      repeat (vt[v].pre) @(negedge clk);
      send_byte(vt[v].n[15:8], 0, ok);
      send_byte(vt[v].n[7:0], pick_gap(vt[v].gap), ok);
      for (int i = 0; i < vt[v].nsend; i++) begin
        wd = vt[v].w[i];
        for (int j = 3; j >= 0; j--) begin
          logic [31:0] t;
          t = wd >> (8 * j);
          if (ok) send_byte(t[7:0], pick_gap(vt[v].gap), ok);
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (24) @(negedge clk);
      chk($sformatf("v%0d_done", v),      64'(bus.done),      64'(vt[v].exp_done));
      chk($sformatf("v%0d_err", v),       64'(bus.err),       64'(vt[v].exp_err));
      chk($sformatf("v%0d_cpu_reset", v), 64'(bus.cpu_reset), 64'(!vt[v].exp_done));
      chk($sformatf("v%0d_in_ready", v),  64'(bus.in_ready),  64'd0);
      chk($sformatf("v%0d_nwrites", v),   64'(wq_addr.size() - base), 64'(vt[v].exp_wr));
      for (int i = 0; i < vt[v].exp_wr; i++) begin
        if (base + i < wq_addr.size()) begin
          chk($sformatf("v%0d_addr%0d", v, i), 64'(wq_addr[base + i]), 64'(i));
          chk($sformatf("v%0d_data%0d", v, i), 64'(wq_data[base + i]), 64'(vt[v].w[i]));
        end
      end
    end

    // Exact write/done timing for the two-word image.
    do_reset(1'b0);
    ok = 1'b1;
    send_byte(8'h00, 0, ok);
    send_byte(8'h02, 0, ok);
    send_word(32'h20080005, 0, ok);
    #1;
    chk("t035_we0",   64'(bus.im_we),    64'd1);
    chk("t035_addr0", 64'(bus.im_addr),  64'd0);
    chk("t035_data0", 64'(bus.im_wdata), 64'h20080005);
    send_word(32'h8C090000, 0, ok);
    #1;
    chk("t035_we1",   64'(bus.im_we),    64'd1);
    chk("t035_addr1", 64'(bus.im_addr),  64'd1);
    chk("t035_data1", 64'(bus.im_wdata), 64'h8C090000);
    chk("t035_done_early", 64'(bus.done), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t035_done",      64'(bus.done),      64'd1);
    chk("t035_cpu_reset", 64'(bus.cpu_reset), 64'd0);
    chk("t035_we_after",  64'(bus.im_we),     64'd0);
    chk("t035_hold_addr", 64'(bus.im_addr),   64'd1);
    chk("t035_hold_data", 64'(bus.im_wdata),  64'h8C090000);

    // Empty image completes the cycle after the second header byte.
    do_reset(1'b0);
    base = wq_addr.size();
    send_byte(8'h00, 0, ok);
    send_byte(8'h00, 0, ok);
    #1;
    chk("t036_done",      64'(bus.done),      64'd1);
    chk("t036_cpu_reset", 64'(bus.cpu_reset), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t036_nwrites", 64'(wq_addr.size() - base), 64'd0);

    // Idle timeout lands exactly TMO+1 cycles after the last accept.
    do_reset(1'b0);
    base = wq_addr.size();
    send_byte(8'h00, 0, ok);
    send_byte(8'h01, 0, ok);
    send_byte(8'hAA, 0, ok);
    send_byte(8'hBB, 0, ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.err && first < 0) first = c;
    end
    chk("t038_err_cycle", 64'(first), 64'(TMO + 1));
    chk("t038_nwrites",   64'(wq_addr.size() - base), 64'd0);

    // Reset mid-load, then a fresh one-word stream.
    do_reset(1'b0);
    ok = 1'b1;
    send_byte(8'h00, 0, ok);
    send_byte(8'h03, 0, ok);
    send_word(32'h01020304, 0, ok);
    send_word(32'h05060708, 0, ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t040_async");
    @(negedge clk);
    reset = 1'b0;
    base = wq_addr.size();
    ok = 1'b1;
    send_byte(8'h00, 0, ok);
    send_byte(8'h01, 0, ok);
    send_word(32'h11223344, 0, ok);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t040_nwrites", 64'(wq_addr.size() - base), 64'd1);
    if (wq_addr.size() > base) begin
      chk("t040_addr", 64'(wq_addr[base]), 64'd0);
      chk("t040_data", 64'(wq_data[base]), 64'h11223344);
    end
    chk("t040_done", 64'(bus.done), 64'd1);

    // Largest legal image: the address must stop at 2^ADDR_W-1.
    do_reset(1'b0);
    base = wq_addr.size();
    ok = 1'b1;
    send_byte(8'h04, 0, ok);
    send_byte(8'h00, 0, ok);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      wd = {16'(i) ^ 16'hA5C3, 16'(i)};
      send_word(wd, 0, ok);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("tmax_nwrites", 64'(wq_addr.size() - base), 64'(1 << ADDR_W));
    bad = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      if (base + i < wq_addr.size()) begin
        wd = {16'(i) ^ 16'hA5C3, 16'(i)};
        if (wq_addr[base + i] !== ADDR_W'(i) || wq_data[base + i] !== wd) bad++;
      end
    end
    chk("tmax_contents", 64'(bad), 64'd0);
    chk("tmax_last_addr", 64'(bus.im_addr), 64'((1 << ADDR_W) - 1));
    chk("tmax_done", 64'(bus.done), 64'd1);
    chk("tmax_err",  64'(bus.err),  64'd0);

    chk("we_single_cycle", 64'(we_runs),    64'd0);
    chk("done_err_excl",   64'(both_flags), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-003 Parameter IDLE_TIMEOUT, default 65535: consecutive idle cycles tolerated mid-load.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream byte valid.
REQ-007 in_data  input  8  upstream byte.
REQ-008 in_ready  output  1  loader can accept a byte.
REQ-009 im_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-010 im_addr  output  ADDR_W  instruction-memory word address.
REQ-011 im_wdata  output  32  instruction word.
REQ-012 cpu_reset  output  1  held high to keep the CPU in reset until the image is loaded.
REQ-013 done  output  1  image loaded successfully, sticky.
REQ-014 err  output  1  load failed, sticky.

Function
REQ-015 A byte SHALL be accepted only on a rising clk edge where in_valid=1 and in_ready=1; in_data is not sampled otherwise.
REQ-016 States: LEN_HI, LEN_LO, DATA, DONE, ERROR.
REQ-017 in_ready SHALL be 1 in LEN_HI, LEN_LO and DATA, 0 in DONE and ERROR, and 0 while reset=1; it is decoded from state only, with no dependence on in_valid.
REQ-018 Stream format: byte 0 = N[15:8], byte 1 = N[7:0] (word count N), then 4*N bytes forming words MSB-first.
REQ-019 LEN_HI: on accept, latch N[15:8] and go to LEN_LO.
REQ-020 LEN_LO: on accept, latch N[7:0]; then N=0 -> DONE; N > 2^ADDR_W -> ERROR; otherwise -> DATA with word counter k=0 and byte counter b=0.
REQ-021 DATA: each accept shifts the byte into a 32-bit assembly register and increments b modulo 4.
REQ-022 On accepting the 4th byte of a word (b=3), the next cycle SHALL show im_we=1, im_addr=k and im_wdata = {byte0,byte1,byte2,byte3}; k then increments.
REQ-023 im_we SHALL be high for exactly one cycle per word; the next byte may be accepted in the same cycle im_we is high.
REQ-024 On the write of word k=N-1, the state SHALL move to DONE; done=1 and cpu_reset=0 from the cycle after that im_we pulse.
REQ-025 N = 2^ADDR_W is legal; the last address written is 2^ADDR_W-1, and im_addr SHALL never wrap.
REQ-026 Idle counter: cleared on every accept and on entering LEN_LO or DATA; increments in LEN_LO and DATA on cycles with no accept.
REQ-027 When the idle counter reaches IDLE_TIMEOUT, the state SHALL move to ERROR on the next edge.
REQ-028 LEN_HI SHALL have no timeout.
REQ-029 ERROR: err=1, cpu_reset stays 1, no further writes; exit only by reset.
REQ-030 DONE: done=1, cpu_reset=0, in_ready=0, im_we=0; exit only by reset.
REQ-031 done and err SHALL never both be 1.
REQ-032 im_addr and im_wdata SHALL hold their last written values when im_we=0.

Reset
REQ-033 While reset=1, regardless of clk: state=LEN_HI, k=b=0, idle counter=0, im_we=0, im_addr=0, im_wdata=0, cpu_reset=1, done=0, err=0, in_ready=0.
REQ-034 Reset asserted mid-load SHALL abort the load immediately; words already written remain in memory, and the next stream is parsed from a fresh length header.

Verification
REQ-035 Stream 00 02 20 08 00 05 8C 09 00 00, in_valid held high -> im_we at addr 0 data 0x20080005, then addr 1 data 0x8C090000; done=1 and cpu_reset=0 one cycle after the second write.
REQ-036 Stream 00 00 -> no im_we; done=1 and cpu_reset=0 the cycle after the second byte is accepted.
REQ-037 ADDR_W=10, header 04 01 (N=1025) -> err=1, in_ready=0, cpu_reset=1, no writes.
REQ-038 IDLE_TIMEOUT=16, header 00 01 then bytes AA BB, then in_valid=0 -> err=1 exactly 17 cycles after the last accept, no write.
REQ-039 N=3 with random in_valid gaps shorter than the timeout -> three writes at addresses 0,1,2 with correct data, each im_we exactly one cycle.
REQ-040 Reset pulsed after 2 of 3 words, then stream 00 01 11 22 33 44 -> a single write at addr 0 with data 0x11223344, then done=1.
